// File: rtl/pb_debouncer_pkg.sv
// Shared defaults and sizing helpers for the push-button debouncer array.
// Default timings assume a 50 MHz system clock.
package pb_debouncer_pkg;

  localparam int CLK_HZ            = 50_000_000;
  // 10 ms acceptance window and 1 s long-press threshold
  localparam int DEF_STABLE_CYCLES = CLK_HZ / 100;
  localparam int DEF_LONG_CYCLES   = CLK_HZ;

  // Bits needed to count 0..value-1, never less than one bit.
  function automatic int cnt_width(input int unsigned value);
    return (value <= 32'd2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/pb_debouncer_array_ch.sv
// Single debounced button channel: synchronizer, stability filter,
// press/release edge pulses and a saturating long-press detector.
module debounce_ch
  import pb_debouncer_pkg::*;
#(
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter bit ACTIVE_LOW    = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic pb_in,
  output logic pb_out,
  output logic rise,
  output logic fall,
  output logic long_press
);

  localparam int SW = cnt_width(STABLE_CYCLES);
  localparam int HW = cnt_width(LONG_CYCLES + 1);
  localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CYCLES - 1);
  localparam logic [HW-1:0] LONG_MAX    = HW'(LONG_CYCLES);
  localparam logic [HW-1:0] LONG_LAST   = HW'(LONG_CYCLES - 1);

  logic          sync1_reg;
  logic          sync2_reg;
  logic          level;
  logic [SW-1:0] stable_cnt_reg, stable_cnt_next;
  logic [HW-1:0] hold_cnt_reg, hold_cnt_next;
  logic          pb_out_reg, pb_out_next;
  logic          rise_reg, rise_next;
  logic          fall_reg, fall_next;

  always_comb begin
    level           = sync2_reg ^ ACTIVE_LOW;
    stable_cnt_next = '0;
    pb_out_next     = pb_out_reg;
    rise_next       = 1'b0;
    fall_next       = 1'b0;
    hold_cnt_next   = '0;

    if (level != pb_out_reg) begin
      if (stable_cnt_reg == STABLE_LAST) begin
        pb_out_next = level;
        rise_next   = level;
        fall_next   = ~level;
      end else begin
        stable_cnt_next = stable_cnt_reg + 1'b1;
      end
    end

    // Saturating above the trigger value keeps long_press to one pulse per press
    if (pb_out_reg) begin
      hold_cnt_next = (hold_cnt_reg == LONG_MAX) ? hold_cnt_reg : hold_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_reg      <= ACTIVE_LOW;
      sync2_reg      <= ACTIVE_LOW;
      stable_cnt_reg <= '0;
      hold_cnt_reg   <= '0;
      pb_out_reg     <= 1'b0;
      rise_reg       <= 1'b0;
      fall_reg       <= 1'b0;
    end else begin
      sync1_reg      <= pb_in;
      sync2_reg      <= sync1_reg;
      stable_cnt_reg <= stable_cnt_next;
      hold_cnt_reg   <= hold_cnt_next;
      pb_out_reg     <= pb_out_next;
      rise_reg       <= rise_next;
      fall_reg       <= fall_next;
    end
  end

  // Hold count is 0 in the rise cycle, so LONG_LAST marks the LONG_CYCLES-th pressed cycle
  assign long_press = pb_out_reg & (hold_cnt_reg == LONG_LAST);
  assign pb_out     = pb_out_reg;
  assign rise       = rise_reg;
  assign fall       = fall_reg;

endmodule

// File: rtl/pb_debouncer_array.sv
// Array of independent debounced push-button channels with a shared
// "any button pressed" flag.
module pb_debouncer_array
  import pb_debouncer_pkg::*;
#(
  parameter int N_CH          = 4,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter bit ACTIVE_LOW    = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] pb_in,
  output logic [N_CH-1:0] pb_out,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic [N_CH-1:0] long_press,
  output logic            any_pressed
);

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      debounce_ch #(
        .STABLE_CYCLES(STABLE_CYCLES),
        .LONG_CYCLES  (LONG_CYCLES),
        .ACTIVE_LOW   (ACTIVE_LOW)
      ) u_ch (
        .clk       (clk),
        .rst       (rst),
        .pb_in     (pb_in[gi]),
        .pb_out    (pb_out[gi]),
        .rise      (rise[gi]),
        .fall      (fall[gi]),
        .long_press(long_press[gi])
      );
    end
  endgenerate

  assign any_pressed = |pb_out;

endmodule

// File: tb/tb_pb_debouncer_array.sv
// Bench for pb_debouncer_array: an active-high and an active-low instance
// share one stimulus and one window-based behavioural model.
module tb_pb_debouncer_array;

  localparam int N = 2;
  localparam int S = 4;
  localparam int L = 10;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] pb_in = '1;

  logic [N-1:0] out_h, rise_h, fall_h, long_h;
  logic         any_h;
  logic [N-1:0] out_l, rise_l, fall_l, long_l;
  logic         any_l;

  always #10 clk = ~clk;

  pb_debouncer_array #(.N_CH(N), .STABLE_CYCLES(S), .LONG_CYCLES(L), .ACTIVE_LOW(1'b0)) dut_h (
    .clk(clk), .rst(rst), .pb_in(pb_in), .pb_out(out_h), .rise(rise_h),
    .fall(fall_h), .long_press(long_h), .any_pressed(any_h));

  pb_debouncer_array #(.N_CH(N), .STABLE_CYCLES(S), .LONG_CYCLES(L), .ACTIVE_LOW(1'b1)) dut_l (
    .clk(clk), .rst(rst), .pb_in(~pb_in), .pb_out(out_l), .rise(rise_l),
    .fall(fall_l), .long_press(long_l), .any_pressed(any_l));

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: the debounced level flips when the last S synchronized samples
  // (raw level delayed two edges) all disagree with it.
  bit           win [N][S+2];
  bit [N-1:0]   m_out = '0, m_rise = '0, m_fall = '0, m_long = '0;
  int           m_press [N];

  always @(posedge clk) begin : model
    bit all_diff;
    cyc++;
    for (int c = 0; c < N; c++) begin
      for (int k = S + 1; k > 0; k--) win[c][k] = win[c][k-1];
      win[c][0] = pb_in[c];
      m_rise[c] = 1'b0;
      m_fall[c] = 1'b0;
      m_long[c] = 1'b0;
      if (!rst) begin
        for (int k = 0; k < S + 2; k++) win[c][k] = 1'b0;
        m_out[c]   = 1'b0;
        m_press[c] = 0;
      end else begin
        all_diff = 1'b1;
        for (int k = 2; k < S + 2; k++) if (win[c][k] == m_out[c]) all_diff = 1'b0;
        if (all_diff) begin
          m_out[c]  = ~m_out[c];
          m_rise[c] = m_out[c];
          m_fall[c] = ~m_out[c];
        end
        if (m_out[c]) begin
          m_press[c] = m_press[c] + 1;
          m_long[c]  = (m_press[c] == L);
        end else begin
          m_press[c] = 0;
        end
      end
    end
  end

  // Event monitor on the active-high instance for the directed checks
  int rise_cnt [N], fall_cnt [N], long_cnt [N], high_cnt [N];
  int rise_cyc [N], fall_cyc [N], long_cyc [N];

  task automatic clear_mon();
    for (int c = 0; c < N; c++) begin
      rise_cnt[c] = 0; fall_cnt[c] = 0; long_cnt[c] = 0; high_cnt[c] = 0;
      rise_cyc[c] = 0; fall_cyc[c] = 0; long_cyc[c] = 0;
    end
  endtask

  always @(posedge clk) begin : compare
    #1;
    chk("pb_out_h", out_h, m_out);
    chk("rise_h", rise_h, m_rise);
    chk("fall_h", fall_h, m_fall);
    chk("long_h", long_h, m_long);
    chk("any_h", any_h, |m_out);
    chk("pb_out_l", out_l, m_out);
    chk("rise_l", rise_l, m_rise);
    chk("fall_l", fall_l, m_fall);
    chk("long_l", long_l, m_long);
    chk("any_l", any_l, |m_out);
    for (int c = 0; c < N; c++) begin
      if (out_h[c])  high_cnt[c]++;
      if (rise_h[c]) begin rise_cnt[c]++; rise_cyc[c] = cyc; end
      if (fall_h[c]) begin fall_cnt[c]++; fall_cyc[c] = cyc; end
      if (long_h[c]) begin long_cnt[c]++; long_cyc[c] = cyc; end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    clear_mon();
    // Reset with both buttons held
    step(3);
    chk("rst_pb_out", out_h, 2'b00);
    chk("rst_pulses", {rise_h, fall_h, long_h}, 6'b0);
    chk("rst_pb_out_l", out_l, 2'b00);
    rst = 1'b1;
    clear_mon();
    step(5);
    chk("post_rst_wait", out_h, 2'b00);
    step(1);
    chk("post_rst_out", out_h, 2'b11);
    chk("post_rst_rise", rise_h, 2'b11);
    chk("post_rst_rise_l", rise_l, 2'b11);
    chk("post_rst_any_l", any_l, 1'b1);
    step(1);
    chk("post_rst_rise_end", rise_h, 2'b00);
    pb_in = 2'b00;
    step(12);

    // Three-cycle glitch is rejected
    clear_mon();
    pb_in[0] = 1'b1;
    step(3);
    pb_in[0] = 1'b0;
    step(10);
    chk("glitch_rise", rise_cnt[0], 0);
    chk("glitch_high", high_cnt[0], 0);

    // Clean six-cycle press
    clear_mon();
    pb_in[0] = 1'b1;
    step(5);
    chk("press_before", out_h[0], 1'b0);
    step(1);
    chk("press_out", out_h[0], 1'b1);
    chk("press_rise", rise_h[0], 1'b1);
    pb_in[0] = 1'b0;
    step(12);
    chk("press_rise_cnt", rise_cnt[0], 1);
    chk("press_fall_cnt", fall_cnt[0], 1);
    chk("press_long_cnt", long_cnt[0], 0);
    chk("press_high", high_cnt[0], 6);
    chk("press_width", fall_cyc[0] - rise_cyc[0], 6);

    // Long press on channel 1
    clear_mon();
    pb_in[1] = 1'b1;
    step(20);
    pb_in[1] = 1'b0;
    step(12);
    chk("long_cnt", long_cnt[1], 1);
    chk("long_delay", long_cyc[1] - rise_cyc[1], 9);
    chk("long_rise_cnt", rise_cnt[1], 1);

    // Bounce for 16 cycles, then settle pressed
    clear_mon();
    for (int i = 0; i < 8; i++) begin
      pb_in[0] = (i % 2 == 0);
      step(2);
    end
    pb_in[0] = 1'b1;
    step(5);
    chk("bounce_before", out_h[0], 1'b0);
    step(1);
    chk("bounce_out", out_h[0], 1'b1);
    step(2);
    chk("bounce_rise_cnt", rise_cnt[0], 1);
    pb_in[0] = 1'b0;
    step(12);

    // Simultaneous events on both channels
    clear_mon();
    pb_in = 2'b11;
    step(6);
    chk("sim_rise", rise_h, 2'b11);
    step(10);
    chk("sim_long0", long_cnt[0], 1);
    chk("sim_long1", long_cnt[1], 1);
    chk("sim_long_same", long_cyc[0] - long_cyc[1], 0);
    pb_in = 2'b00;
    step(6);
    chk("sim_fall", fall_h, 2'b11);
    chk("sim_any", any_h, 1'b0);
    step(6);

    // Reset mid-count, then button held through reset release
    clear_mon();
    pb_in[0] = 1'b1;
    step(3);
    rst = 1'b0;
    step(2);
    chk("midrst_out", out_h, 2'b00);
    rst = 1'b1;
    step(5);
    chk("midrst_before", out_h[0], 1'b0);
    chk("midrst_no_rise", rise_cnt[0], 0);
    step(1);
    chk("midrst_rise", rise_h[0], 1'b1);
    // Reset entry while pressed gives no release pulse
    rst = 1'b0;
    step(1);
    chk("rst_entry_out", out_h[0], 1'b0);
    chk("rst_entry_fall", fall_cnt[0], 0);
    rst = 1'b1;
    pb_in = 2'b00;
    step(12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
